// File: rtl/scroll_buf_pkg.sv
// Shared types for the scroll buffer: command op encoding and control FSM states.
package scroll_buf_pkg;

  typedef enum logic [1:0] {
    OpShift  = 2'd0,
    OpRotate = 2'd1,
    OpLoad   = 2'd2,
    OpClear  = 2'd3
  } op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/scroll_row.sv
// One display row: a COLS-bit shift/rotate register with load, clear and an ejected-bit flop.
module scroll_row #(
  parameter int unsigned COLS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic            load,
  input  logic            clear,
  input  logic            dir,
  input  logic            rotate,
  input  logic            fill,
  input  logic [COLS-1:0] load_val,
  output logic [COLS-1:0] row,
  output logic            ex
);

  logic [COLS-1:0] row_q, row_d;
  logic            ex_q, ex_d;
  logic            out_bit;
  logic            in_bit;

  // dir=0 ejects the MSB, dir=1 ejects the LSB; rotate feeds the ejected bit back in.
  assign out_bit = dir ? row_q[0] : row_q[COLS-1];
  assign in_bit  = rotate ? out_bit : fill;

  always_comb begin
    row_d = row_q;
    ex_d  = ex_q;
    if (clear) begin
      row_d = '0;
      ex_d  = 1'b0;
    end else if (load) begin
      row_d = load_val;
    end else if (step) begin
      ex_d = out_bit;
      if (!dir) begin
        row_d = (row_q << 1) | COLS'(in_bit);
      end else begin
        row_d = (row_q >> 1) | (COLS'(in_bit) << (COLS - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      ex_q  <= 1'b0;
    end else begin
      row_q <= row_d;
      ex_q  <= ex_d;
    end
  end

  assign row = row_q;
  assign ex  = ex_q;

endmodule

// File: rtl/scroll_buf.sv
// Scrolling pixel buffer: IDLE/RUN command FSM with step counter driving ROWS scroll_row registers.
// Define SCROLL_BUF_PACE_EN to pace RUN steps with the tick strobe; otherwise tick is ignored.
module scroll_buf
  import scroll_buf_pkg::*;
#(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic                 dir,
  input  logic [CNT_W-1:0]     count,
  input  logic [ROWS-1:0]      d,
  input  logic [ROWS*COLS-1:0] load_data,
  input  logic                 tick,
  output logic [ROWS-1:0]      ex,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*COLS-1:0] out
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               rot_q, rot_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               accept;
  logic               step_en;
  logic               step;
  logic               load;
  logic               clear;
  logic [ROWS*COLS-1:0] pix;

`ifdef SCROLL_BUF_PACE_EN
  assign step_en = (state_q == StRun) && tick;
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign step_en     = (state_q == StRun);
`endif

  assign accept = cmd_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rot_d   = rot_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    step    = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (op_e'(cmd_op))
            OpLoad: begin
              load   = 1'b1;
              done_d = 1'b1;
            end
            OpClear: begin
              clear  = 1'b1;
              done_d = 1'b1;
            end
            OpShift, OpRotate: begin
              if (count == '0) begin
                done_d = 1'b1;
              end else begin
                rem_d   = count;
                rot_d   = (op_e'(cmd_op) == OpRotate);
                dir_d   = dir;
                state_d = StRun;
              end
            end
          endcase
        end
      end
      StRun: begin
        if (step_en) begin
          step  = 1'b1;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      rot_q   <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      rot_q   <= rot_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    scroll_row #(
      .COLS(COLS)
    ) u_row (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step),
      .load     (load),
      .clear    (clear),
      .dir      (dir_q),
      .rotate   (rot_q),
      .fill     (d[r]),
      .load_val (load_data[r*COLS +: COLS]),
      .row      (pix[r*COLS +: COLS]),
      .ex       (ex[r])
    );
  end

  // Outputs are forced to their idle values while reset is held, even before the first edge.
  assign cmd_ready = (state_q == StIdle) || !rst_n;
  assign busy      = (state_q == StRun) && rst_n;
  assign done      = done_q && rst_n;
  assign out       = rst_n ? pix : '0;

endmodule

// File: tb/tb_scroll_buf.sv
// Directed self-checking bench for scroll_buf (8x8, CNT_W=6); paced scenario under SCROLL_BUF_PACE_EN.
module tb_scroll_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        dir;
  logic [5:0]  count;
  logic [7:0]  d;
  logic [63:0] load_data;
  logic        tick;
  logic [7:0]  ex;
  logic        busy;
  logic        done;
  logic [63:0] out;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] Pat = 64'hDEADBEEF0123A5C3;

  scroll_buf #(
    .ROWS (8),
    .COLS (8),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .dir      (dir),
    .count    (count),
    .d        (d),
    .load_data(load_data),
    .tick     (tick),
    .ex       (ex),
    .busy     (busy),
    .done     (done),
    .out      (out)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference step of the whole 8x8 image.
  function automatic logic [63:0] step_img(input logic [63:0] img, input logic dr, input logic rot,
                                           input logic [7:0] dv, output logic [7:0] exv);
    logic [63:0] res;
    logic [7:0]  row;
    logic        b;
    for (int r = 0; r < 8; r++) begin
      row = img[r*8 +: 8];
      if (!dr) begin
        exv[r] = row[7];
        b = rot ? row[7] : dv[r];
        res[r*8 +: 8] = {row[6:0], b};
      end else begin
        exv[r] = row[0];
        b = rot ? row[0] : dv[r];
        res[r*8 +: 8] = {b, row[7:1]};
      end
    end
    return res;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic dr, input logic [5:0] cnt,
                       input logic [63:0] ld);
    cmd_valid = 1'b1;
    cmd_op    = op;
    dir       = dr;
    count     = cnt;
    load_data = ld;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    total++; if (out !== 64'h0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++; if (ex !== 8'h0) begin bad++; $display("FAIL reset_ex got=%h want=0", ex); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_shift_load();
    issue(2'd2, 1'b0, 6'd0, 64'h8040201008040201);
    total++; if (out !== 64'h8040201008040201) begin bad++; $display("FAIL load_out got=%h want=8040201008040201", out); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL load_done got=%b want=1", done); end
    d = 8'hFF;
    issue(2'd0, 1'b0, 6'd1, 64'h0);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL shift_run busy=%b done=%b want 1 0", busy, done); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL shift_ready got=%b want=0", cmd_ready); end
    cyc();
    total++; if (out !== 64'h0181412111090503) begin bad++; $display("FAIL shift_out got=%h want=0181412111090503", out); end
    total++; if (ex !== 8'h80) begin bad++; $display("FAIL shift_ex got=%h want=80", ex); end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL shift_done done=%b busy=%b want 1 0", done, busy); end
    cyc();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL shift_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_rotate();
    logic [63:0] exp_img;
    logic [7:0]  exv;
    issue(2'd2, 1'b0, 6'd0, Pat);
    total++; if (ex !== 8'h80) begin bad++; $display("FAIL load_keeps_ex got=%h want=80", ex); end
    issue(2'd1, 1'b1, 6'd8, 64'h0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rot_busy0 got=%b want=1", busy); end
    exp_img = Pat;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp_img = step_img(exp_img, 1'b1, 1'b1, 8'h00, exv);
      total++; if (out !== exp_img) begin bad++; $display("FAIL rot_out step=%0d got=%h want=%h", i, out, exp_img); end
      total++; if (busy !== (i < 8)) begin bad++; $display("FAIL rot_busy step=%0d got=%b", i, busy); end
      total++; if (done !== (i == 8)) begin bad++; $display("FAIL rot_done step=%0d got=%b", i, done); end
    end
    total++; if (out !== Pat) begin bad++; $display("FAIL rot_restore got=%h want=%h", out, Pat); end
    total++; if (ex !== 8'hF3) begin bad++; $display("FAIL rot_ex got=%h want=f3", ex); end
    cyc();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rot_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_count_zero();
    issue(2'd0, 1'b0, 6'd0, 64'h0);
    total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL zero_cnt busy=%b done=%b want 0 1", busy, done); end
    total++; if (out !== Pat) begin bad++; $display("FAIL zero_out got=%h want=%h", out, Pat); end
    cyc();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL zero_after busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_live_d();
    logic [63:0] exp_img;
    logic [7:0]  exv;
    issue(2'd0, 1'b1, 6'd2, 64'h0);
    d = 8'hAA;
    cyc();
    d = 8'h55;
    cyc();
    exp_img = step_img(Pat, 1'b1, 1'b0, 8'hAA, exv);
    exp_img = step_img(exp_img, 1'b1, 1'b0, 8'h55, exv);
    total++; if (out !== exp_img) begin bad++; $display("FAIL live_d_out got=%h want=%h", out, exp_img); end
    total++; if (ex !== exv) begin bad++; $display("FAIL live_d_ex got=%h want=%h", ex, exv); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL live_d_done got=%b want=1", done); end
  endtask

  task automatic test_ignore_abort();
    logic [63:0] exp_img;
    logic [7:0]  exv;
    issue(2'd2, 1'b0, 6'd0, Pat);
    d = 8'h00;
    issue(2'd0, 1'b0, 6'd5, 64'h0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cyc();
    cmd_valid = 1'b0;
    exp_img = step_img(Pat, 1'b0, 1'b0, 8'h00, exv);
    total++; if (out !== exp_img) begin bad++; $display("FAIL clear_ignored got=%h want=%h", out, exp_img); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    cyc();
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_state busy=%b ready=%b want 0 1", busy, cmd_ready); end
    total++; if (out !== 64'h0 || ex !== 8'h0) begin bad++; $display("FAIL abort_clr out=%h ex=%h want 0 0", out, ex); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_no_done cyc=%0d done=%b busy=%b", i, done, busy); end
      cyc();
    end
  endtask

  task automatic test_tick();
    logic [63:0] exp_img;
    logic [7:0]  exv;
    int          steps;
    issue(2'd2, 1'b0, 6'd0, Pat);
    d = 8'h0F;
`ifdef SCROLL_BUF_PACE_EN
    tick = 1'b0;
    issue(2'd0, 1'b0, 6'd2, 64'h0);
    exp_img = Pat;
    steps = 0;
    for (int k = 0; k < 9; k++) begin
      tick = (k % 3 == 2);
      cyc();
      if (tick && steps < 2) begin
        exp_img = step_img(exp_img, 1'b0, 1'b0, 8'h0F, exv);
        steps++;
      end
      total++; if (out !== exp_img) begin bad++; $display("FAIL pace_out k=%0d got=%h want=%h", k, out, exp_img); end
      total++; if (done !== (k == 5)) begin bad++; $display("FAIL pace_done k=%0d got=%b", k, done); end
      tick = 1'b0;
    end
`else
    tick = 1'b0;
    issue(2'd0, 1'b0, 6'd2, 64'h0);
    exp_img = step_img(Pat, 1'b0, 1'b0, 8'h0F, exv);
    cyc();
    total++; if (out !== exp_img || busy !== 1'b1) begin bad++; $display("FAIL notick_step1 out=%h busy=%b want %h 1", out, busy, exp_img); end
    exp_img = step_img(exp_img, 1'b0, 1'b0, 8'h0F, exv);
    cyc();
    total++; if (out !== exp_img || done !== 1'b1) begin bad++; $display("FAIL notick_step2 out=%h done=%b want %h 1", out, done, exp_img); end
`endif
    tick = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    dir       = 1'b0;
    count     = 6'd0;
    d         = 8'h00;
    load_data = 64'h0;
    tick      = 1'b1;
    test_reset();
    test_shift_load();
    test_rotate();
    test_count_zero();
    test_live_d();
    test_ignore_abort();
    test_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
